// File: rtl/alarm_trigger.sv
`default_nettype none
// ============================================================================
// Module      : alarm_trigger
// Description : Decides when the alarm rings. Matches the time-of-day
//               against the programmed alarm time once per second and runs
//               a ring / snooze / stop state machine driven by two buttons.
//               The ringing stops automatically after RING_SECS seconds.
//               Optional feature macro: ALARM_SNOOZE_EN (adds the SNOOZE
//               state, the snooze counter and the snooze button path).
// Revision    : 1.0 - initial release
// ============================================================================
module alarm_trigger #(
   parameter int unsigned RING_SECS   = 60,   // 1..255
   parameter int unsigned SNOOZE_SECS = 300,  // 1..1023
   parameter int unsigned MAX_SNOOZE  = 3     // 1..3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick_1hz,
   input  logic [4:0] cur_hh,
   input  logic [5:0] cur_mm,
   input  logic [5:0] cur_ss,
   input  logic [4:0] alarm_hh,
   input  logic [5:0] alarm_mm,
   input  logic       alarm_en,
   input  logic       stop_btn,
   input  logic       snooze_btn,
   output logic       alarm_signal,
   output logic       snoozing,
   output logic [1:0] snooze_left
);

   // Encoding chosen so each output is a single state bit.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_RINGING = 2'b01,
      ST_SNOOZE  = 2'b10
   } state_t;

   localparam logic [7:0] c_ring_secs = 8'(RING_SECS);

   state_t     state_q, state_d;
   logic [7:0] ring_cnt_q, ring_cnt_d;
   logic [7:0] w_ring_inc;
   logic       w_ring_done;
   logic       w_match;

   // ------------------------------------------------------------------------
   // Stop button: 2-flop synchronizer, then registered rising-edge pulse
   // ------------------------------------------------------------------------
   logic stop_s1_q, stop_s1_d;
   logic stop_s2_q, stop_s2_d;
   logic stop_prev_q, stop_prev_d;
   logic stop_p_q, stop_p_d;

   // Next values of the stop synchronizer and edge detector.
   always_comb begin
      stop_s1_d   = stop_btn;
      stop_s2_d   = stop_s1_q;
      stop_prev_d = stop_s2_q;
      stop_p_d    = stop_s2_q & ~stop_prev_q;
   end

   // Stop synchronizer and edge detector flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stop_s1_q   <= 1'b0;
         stop_s2_q   <= 1'b0;
         stop_prev_q <= 1'b0;
         stop_p_q    <= 1'b0;
      end else begin
         stop_s1_q   <= stop_s1_d;
         stop_s2_q   <= stop_s2_d;
         stop_prev_q <= stop_prev_d;
         stop_p_q    <= stop_p_d;
      end
   end

`ifdef ALARM_SNOOZE_EN
   // ------------------------------------------------------------------------
   // Snooze button path, snooze counter and snooze budget
   // ------------------------------------------------------------------------
   localparam logic [9:0] c_snz_secs   = 10'(SNOOZE_SECS);
   localparam logic [1:0] c_max_snooze = 2'(MAX_SNOOZE);

   logic       snz_s1_q, snz_s1_d;
   logic       snz_s2_q, snz_s2_d;
   logic       snz_prev_q, snz_prev_d;
   logic       snz_p_q, snz_p_d;
   logic [9:0] snz_cnt_q, snz_cnt_d;
   logic [9:0] w_snz_inc;
   logic       w_snz_done;
   logic [1:0] snooze_left_q, snooze_left_d;

   // Next values of the snooze synchronizer and edge detector.
   always_comb begin
      snz_s1_d   = snooze_btn;
      snz_s2_d   = snz_s1_q;
      snz_prev_d = snz_s2_q;
      snz_p_d    = snz_s2_q & ~snz_prev_q;
   end

   // Snooze synchronizer and edge detector flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snz_s1_q   <= 1'b0;
         snz_s2_q   <= 1'b0;
         snz_prev_q <= 1'b0;
         snz_p_q    <= 1'b0;
      end else begin
         snz_s1_q   <= snz_s1_d;
         snz_s2_q   <= snz_s2_d;
         snz_prev_q <= snz_prev_d;
         snz_p_q    <= snz_p_d;
      end
   end

   // Saturating increment and timeout detect for the snooze counter.
   always_comb begin
      w_snz_inc  = (snz_cnt_q == 10'h3FF) ? snz_cnt_q : snz_cnt_q + 10'd1;
      w_snz_done = tick_1hz & (w_snz_inc >= c_snz_secs);
   end

   // Snooze counter and remaining-snooze budget flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snz_cnt_q     <= 10'd0;
         snooze_left_q <= c_max_snooze;
      end else begin
         snz_cnt_q     <= snz_cnt_d;
         snooze_left_q <= snooze_left_d;
      end
   end

   assign snoozing    = state_q[1];
   assign snooze_left = snooze_left_q;
`else
   // Snooze feature absent: the button and its timing parameters are unused.
   localparam int unsigned c_unused_snz_secs = SNOOZE_SECS;
   localparam int unsigned c_unused_max_snz  = MAX_SNOOZE;
   logic w_unused_snooze_btn;

   assign w_unused_snooze_btn = snooze_btn;
   assign snoozing            = 1'b0;
   assign snooze_left         = 2'b00;
`endif

   // ------------------------------------------------------------------------
   // Alarm match and ring counter helpers
   // ------------------------------------------------------------------------
   // Time match is only meaningful on the once-per-second tick at second 0.
   always_comb begin
      w_match     = alarm_en & tick_1hz &
                    (cur_hh == alarm_hh) & (cur_mm == alarm_mm) &
                    (cur_ss == 6'd0);
      w_ring_inc  = (ring_cnt_q == 8'hFF) ? ring_cnt_q : ring_cnt_q + 8'd1;
      w_ring_done = tick_1hz & (w_ring_inc >= c_ring_secs);
   end

   // ------------------------------------------------------------------------
   // State machine
   // ------------------------------------------------------------------------
   // Next state and counter updates; priority is
   // disable > stop > snooze > timeout > match.
   always_comb begin
      state_d    = state_q;
      ring_cnt_d = ring_cnt_q;
`ifdef ALARM_SNOOZE_EN
      snz_cnt_d     = snz_cnt_q;
      snooze_left_d = snooze_left_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (w_match) begin
               state_d = ST_RINGING;
`ifdef ALARM_SNOOZE_EN
               snooze_left_d = c_max_snooze;
`endif
            end
         end
         ST_RINGING: begin
            if (tick_1hz) begin
               ring_cnt_d = w_ring_inc;
            end
            if (stop_p_q) begin
               state_d = ST_IDLE;
`ifdef ALARM_SNOOZE_EN
            end else if (snz_p_q && (snooze_left_q != 2'd0)) begin
               state_d       = ST_SNOOZE;
               snooze_left_d = snooze_left_q - 2'd1;
`endif
            end else if (w_ring_done) begin
               state_d = ST_IDLE;
            end
         end
`ifdef ALARM_SNOOZE_EN
         ST_SNOOZE: begin
            if (tick_1hz) begin
               snz_cnt_d = w_snz_inc;
            end
            if (stop_p_q) begin
               state_d = ST_IDLE;
            end else if (w_snz_done) begin
               state_d = ST_RINGING;
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Disarming the alarm wins over everything else.
      if (!alarm_en) begin
         state_d = ST_IDLE;
      end

      // Every state entry starts the counters from zero.
      if (state_d != state_q) begin
         ring_cnt_d = 8'd0;
`ifdef ALARM_SNOOZE_EN
         snz_cnt_d  = 10'd0;
`endif
      end
   end

   // State register and ring counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         ring_cnt_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         ring_cnt_q <= ring_cnt_d;
      end
   end

   assign alarm_signal = state_q[0];

endmodule
`default_nettype wire
